// File: rtl/coo_pkg.sv
// Shared definitions for the COO sparse-stream encoder/decoder pair:
// default field widths, decoder state codes and the sparse entry record.
package coo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IDX_W_DEF  = 16;

  // Decoder states; plain constants so legacy code can compare them directly.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One sparse beat as carried on the encoded link.
  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] val;
    logic                  is_null;
    logic                  last;
  } coo_entry_t;

endpackage

// File: rtl/coo_dec_stall_mon.sv
// Stall observer for coo_dec: counts consecutive stalled cycles and raises
// a registered block flag once the stall has lasted STALL_LIMIT cycles.
// Only instantiated when COO_DEC_DEADLOCK_MON_EN is defined.
module coo_dec_stall_mon
  import coo_pkg::*;
#(
  parameter int STALL_LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  output logic block
);

  localparam int              CW     = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0]   SAT_V  = CW'(STALL_LIMIT);
  localparam logic [CW-1:0]   LIM_M1 = CW'(STALL_LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          block_q, block_d;

  // Saturating run-length of the stall condition; any non-stall cycle clears it.
  always_comb begin
    cnt_d   = '0;
    block_d = 1'b0;
    if (stall) begin
      cnt_d   = (cnt_q == SAT_V) ? cnt_q : cnt_q + 1'b1;
      block_d = (cnt_q >= LIM_M1);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block = block_q;

endmodule

// File: rtl/coo_dec.sv
// coo_dec: streaming COO-to-dense decoder. Takes ascending (index, value)
// entries and emits exactly LEN dense words per frame, zero-filling gaps.
// Optional stall monitor enabled by defining COO_DEC_DEADLOCK_MON_EN.
module coo_dec
  import coo_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int LEN         = 1024,
  parameter int STALL_LIMIT = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_val,
  input  logic              in_null,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [15:0]       frame_cnt,
  output logic              block
);

  // LEN may equal 2**IDX_W, so the range check is done one bit wider.
  localparam logic [IDX_W:0]   LEN_X    = (IDX_W + 1)'(LEN);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              ld;
  logic              emit;
  logic [DATA_W-1:0] emit_val;
  logic              in_ready_c;
  logic              idx_lt, idx_oob, idx_eq, at_end;

  // Decode decision for this cycle: what to emit, what to consume, next state.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    in_ready_c  = 1'b0;
    emit        = 1'b0;
    emit_val    = '0;

    ld      = !out_valid_q || out_ready;
    idx_lt  = in_idx < pos_q;
    idx_oob = {1'b0, in_idx} >= LEN_X;
    idx_eq  = in_idx == pos_q;
    at_end  = pos_q == LAST_POS;

    if (ld) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        in_ready_c = ld && in_valid && (in_null || idx_lt || idx_oob || idx_eq);
        if (ld && in_valid) begin
          if (in_null) begin
            if (in_last) state_d = ST_FILL;
          end else if (idx_lt || idx_oob) begin
            err_d = 1'b1;
            if (in_last) state_d = ST_FILL;
          end else if (idx_eq) begin
            emit     = 1'b1;
            emit_val = in_val;
            if (at_end) begin
              if (!in_last) state_d = ST_DRAIN;
            end else if (in_last) begin
              state_d = ST_FILL;
            end
          end else begin
            emit = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (ld) begin
          emit = 1'b1;
          if (at_end) state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          if (!in_null) err_d = 1'b1;
          if (in_last) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_val;
      out_last_d  = at_end;
      if (at_end) begin
        pos_d       = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // State, position and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;

`ifdef COO_DEC_DEADLOCK_MON_EN
  logic stall_c;

  // Stalled when the consumer holds us off, or a frame is open but starved.
  assign stall_c = (out_valid_q && !out_ready) ||
                   (state_q == ST_RUN && !in_valid && pos_q != '0);

  coo_dec_stall_mon #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_mon (
    .clock (clock),
    .reset (reset),
    .stall (stall_c),
    .block (block)
  );
`else
  // Monitor not built: block stays low whatever STALL_LIMIT is.
  assign block = (STALL_LIMIT > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_coo_dec.sv
// Scoreboard bench for coo_dec with LEN=8: stimulus pushes expected dense
// beats into a queue; a negedge monitor pops and compares on each handshake
// and also checks that a stalled output word is held unchanged.
module tb_coo_dec;

  localparam int DW = 32;
  localparam int IW = 16;

`ifdef COO_DEC_DEADLOCK_MON_EN
  localparam logic MON = 1'b1;
`else
  localparam logic MON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] in_idx = '0;
  logic [DW-1:0] in_val = '0;
  logic          in_null = 1'b0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          err;
  logic [15:0]   frame_cnt;
  logic          block;

  int total = 0;
  int bad   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] held;
  bit          holding = 0;

  logic [DW-1:0] e1 [8];
  logic [DW-1:0] e3 [8];

  coo_dec #(
    .DATA_W      (DW),
    .IDX_W       (IW),
    .LEN         (8),
    .STALL_LIMIT (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_idx    (in_idx),
    .in_val    (in_val),
    .in_null   (in_null),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .frame_cnt (frame_cnt),
    .block     (block)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Monitor: compare each accepted output beat with the scoreboard head.
  always @(negedge clock) begin
    if (reset) begin
      holding = 0;
    end else begin
      if (holding)
        check("hold", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_beat: got %0h expected none", {out_last, out_data});
        end else begin
          check("beat", {31'd0, out_last, out_data}, {31'd0, exp_q.pop_front()});
        end
      end
      holding = out_valid && !out_ready;
      held    = {out_last, out_data};
    end
  end

  task automatic applyStimulus_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    check("rst_block", {63'd0, block}, 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic applyStimulus_beat(input logic [IW-1:0] idx, input logic [DW-1:0] val,
                                    input logic nul, input logic lst);
    bit ok = 0;
    in_idx = idx; in_val = val; in_null = nul; in_last = lst; in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    check("beat_accepted", {63'd0, ok}, 64'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Wait until the scoreboard empties, optionally toggling out_ready.
  task automatic checkOutput_drain(input bit tog);
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(posedge clock);
      #1 if (tog) out_ready = ~out_ready;
    end
    check("drain", {63'd0, ok}, 64'd1);
    @(posedge clock);
    #1 out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    e1 = '{32'h0, 32'hA, 32'h0, 32'h0, 32'hB, 32'h0, 32'h0, 32'h0};
    e3 = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h3, 32'h0, 32'h0};

    // Sparse frame with gaps and an early last.
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) push_exp(e1[i], i == 7);
    applyStimulus_beat(16'd1, 32'hA, 1'b0, 1'b0);
    applyStimulus_beat(16'd4, 32'hB, 1'b0, 1'b1);
    checkOutput_drain(0);
    check("t1_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    check("t1_err", {63'd0, err}, 64'd0);

    // Empty frame: lone null terminator.
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) push_exp(32'h0, i == 7);
    applyStimulus_beat(16'd0, 32'h0, 1'b1, 1'b1);
    checkOutput_drain(0);
    check("t2_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    check("t2_err", {63'd0, err}, 64'd0);

    // Out-of-order entry is dropped and flagged.
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) push_exp(e3[i], i == 7);
    applyStimulus_beat(16'd3, 32'h1, 1'b0, 1'b0);
    check("t3_err_before", {63'd0, err}, 64'd0);
    applyStimulus_beat(16'd2, 32'h2, 1'b0, 1'b0);
    check("t3_err_after", {63'd0, err}, 64'd1);
    applyStimulus_beat(16'd5, 32'h3, 1'b0, 1'b1);
    checkOutput_drain(0);
    check("t3_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    check("t3_err_sticky", {63'd0, err}, 64'd1);

    // Fully dense frame, overflow entry drained, then a normal frame.
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) push_exp(32'h10 + 32'(i), i == 7);
    for (int i = 0; i < 8; i++) push_exp(e1[i], i == 7);
    for (int i = 0; i < 8; i++) applyStimulus_beat(16'(i), 32'h10 + 32'(i), 1'b0, 1'b0);
    applyStimulus_beat(16'd9, 32'h99, 1'b0, 1'b1);
    applyStimulus_beat(16'd1, 32'hA, 1'b0, 1'b0);
    applyStimulus_beat(16'd4, 32'hB, 1'b0, 1'b1);
    checkOutput_drain(0);
    check("t4_frame_cnt", {48'd0, frame_cnt}, 64'd2);
    check("t4_err", {63'd0, err}, 64'd1);

    // Zero frame under a 1010 out_ready pattern.
    applyStimulus_reset();
    for (int i = 0; i < 8; i++) push_exp(32'h0, i == 7);
    applyStimulus_beat(16'd0, 32'h0, 1'b1, 1'b1);
    checkOutput_drain(1);
    check("t5_frame_cnt", {48'd0, frame_cnt}, 64'd1);

    // Long output stall: block rises after four stalled cycles when built in.
    applyStimulus_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_exp(32'h0, i == 7);
    applyStimulus_beat(16'd0, 32'h0, 1'b1, 1'b1);
    begin
      bit seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        if (out_valid) begin seen = 1; break; end
      end
      check("t6_valid_seen", {63'd0, seen}, 64'd1);
    end
    repeat (3) @(negedge clock);
    check("t6_block_k4", {63'd0, block}, 64'd0);
    @(negedge clock);
    check("t6_block_k5", {63'd0, block}, {63'd0, MON});
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    check("t6_block_release", {63'd0, block}, {63'd0, MON});
    @(negedge clock);
    check("t6_block_clear", {63'd0, block}, 64'd0);
    @(posedge clock);
    #1;
    checkOutput_drain(0);
    check("t6_frame_cnt", {48'd0, frame_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coo_dec.md
Name: coo_dec

Overview:
- Streaming COO-to-dense decoder; the receive-side counterpart of the coo_enc encoder.
- Accepts a frame of sparse (index, value) entries in strictly ascending index order.
- Emits a dense frame of exactly LEN values, inserting zeros at absent indices.
- Sits downstream of the encoded AXI-Stream link; carries the same stall-observability hook as the encoder's deadlock monitoring.

Parameters:
DATA_W, 32, width of value field and dense output word
IDX_W, 16, width of index field and position counter
LEN, 1024, dense elements per frame (2..2**IDX_W)
STALL_LIMIT, 256, cycles of continuous stall before block asserts (feature only)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
in_idx  in  IDX_W  entry linear index
in_val  in  DATA_W  entry value
in_null  in  1  beat carries no entry (empty-frame / terminator)
in_last  in  1  last beat of sparse frame
in_valid  in  1  input handshake
in_ready  out  1  input handshake
out_data  out  DATA_W  dense value
out_last  out  1  high on dense element LEN-1
out_valid  out  1  output handshake
out_ready  in  1  output handshake
err  out  1  sticky protocol error
frame_cnt  out  16  completed dense frames, wraps at 2**16
block  out  1  stall detected (tied 0 without feature)

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, err=0, frame_cnt=0, block=0, pos=0, state=RUN.
- Output register loads when ld = !out_valid | out_ready. Data appears on out_* one cycle after the producing decision. Full throughput: 1 beat/cycle.
- in_ready is combinational:
  - RUN: ld & in_valid & (in_null | idx<pos | idx>=LEN | idx==pos).
  - DRAIN: 1.
  - FILL: 0.
- RUN, in_valid, ld:
  - in_null: consume, no output; if in_last go FILL, else ignore.
  - idx<pos or idx>=LEN: consume, set err, no output; if in_last go FILL.
  - idx>pos: emit 0, pos++, input not consumed.
  - idx==pos: consume, emit in_val, pos++.
  - After emit at pos==LEN-1: out_last=1, pos←0, frame_cnt++.
    - If the consumed beat had in_last, stay RUN.
    - Otherwise go DRAIN; entries past LEN are an error, set err.
  - in_last consumed with pos<LEN-1 after emit: go FILL.
- RUN with !in_valid: no output; pos holds.
- FILL: on each ld, emit 0, pos++. At pos==LEN-1: out_last=1, pos←0, frame_cnt++, go RUN.
- DRAIN: discard beats; on consumed in_last go RUN. No output in DRAIN.
- pos is IDX_W bits and never exceeds LEN-1. Comparisons are unsigned.
- out_data/out_last hold while out_valid & !out_ready. Output never drops valid without a handshake.
- err clears only on reset.
- Reset mid-frame: partial frame abandoned; state as reset. No out_last is generated for the abandoned frame.

Optional Feature:
- Macro COO_DEC_DEADLOCK_MON_EN.
- Defined:
  - Counter increments each cycle where (out_valid & !out_ready) or (state==RUN & !in_valid & pos!=0); otherwise clears.
  - block registered high while counter ≥ STALL_LIMIT-1; counter saturates.
  - block deasserts the cycle after the stall condition ends.
- Undefined: counter absent, block constant 0.

Decomposition:
- Package coo_pkg: state enum (RUN, FILL, DRAIN), default widths DATA_W/IDX_W, and an entry struct {idx, val, null, last} shared with coo_enc.
- One natural sub-module: coo_dec_stall_mon (counter plus block register), instantiated only under the macro.

Test Plan:
- LEN=8, entries (1,0xA),(4,0xB,last), out_ready=1 → output 0,A,0,0,B,0,0,0; last on 8th; frame_cnt=1; err=0.
- LEN=8, single beat in_null=1,in_last=1 → eight zeros, out_last on 8th, frame_cnt=1.
- LEN=8, entries (3,1),(2,2),(5,3,last) → out 0,0,0,1,0,3,0,0; err=1 after (2,2) consumed.
- LEN=8, entries 0..7 dense then (9,x,last) → values emitted, out_last on idx7, DRAIN consumes (9,x), err=1, next frame decodes normally.
- out_ready toggled 1010… on a full-zero frame → each value held stable while stalled; exactly 8 beats; no duplicates or drops.
- COO_DEC_DEADLOCK_MON_EN, STALL_LIMIT=4, out_ready=0 with out_valid=1 → block rises after 4 stall cycles; falls one cycle after out_ready=1.
